// File: rtl/operand_fetch.sv
// operand_fetch: gathers rs1/rs2 operands from the register file for each
// decoded instruction and presents them downstream on a valid/ready channel.
// A single-entry writeback buffer drives the register-file write channel and
// blocks reads of registers whose newest value has not been written yet.
// Optional feature macro: OPERAND_FWD_EN (forward buffered writeback data
// into a matching source instead of stalling decode).
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  // decode side
  input  logic            i_dec_valid,
  output logic            o_dec_ready,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  input  logic            i_dec_use_rs1,
  input  logic            i_dec_use_rs2,
  // rs1 read channels
  output logic            o_rs1_arvalid,
  input  logic            i_rs1_arready,
  output logic [4:0]      o_rs1_araddr,
  input  logic            i_rs1_rvalid,
  output logic            o_rs1_rready,
  input  logic [XLEN-1:0] i_rs1_rdata,
  // rs2 read channels
  output logic            o_rs2_arvalid,
  input  logic            i_rs2_arready,
  output logic [4:0]      o_rs2_araddr,
  input  logic            i_rs2_rvalid,
  output logic            o_rs2_rready,
  input  logic [XLEN-1:0] i_rs2_rdata,
  // operand output
  output logic            o_op_valid,
  input  logic            i_op_ready,
  output logic [XLEN-1:0] o_op_rs1_data,
  output logic [XLEN-1:0] o_op_rs2_data,
  // writeback request
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  // register-file write channel
  output logic            o_rd_wvalid,
  input  logic            i_rd_wready,
  output logic [4:0]      o_rd_waddr,
  output logic [XLEN-1:0] o_rd_wdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  logic [1:0] state;

  logic dec_hs, op_hs, wb_hs, rd_hs;
  logic skip1, skip2, match1, match2, hazard;
  logic fwd1, fwd2, need1, need2;
  logic done1_nxt, done2_nxt;

  // Handshakes and per-source classification of the current decode
  always_comb begin
    dec_hs = i_dec_valid & o_dec_ready;
    op_hs  = o_op_valid & i_op_ready;
    rd_hs  = o_rd_wvalid & i_rd_wready;
    wb_hs  = i_wb_valid & o_wb_ready;

    skip1  = ~i_dec_use_rs1 | (i_dec_rs1 == 5'd0);
    skip2  = ~i_dec_use_rs2 | (i_dec_rs2 == 5'd0);
    match1 = o_rd_wvalid & ~skip1 & (i_dec_rs1 == o_rd_waddr);
    match2 = o_rd_wvalid & ~skip2 & (i_dec_rs2 == o_rd_waddr);
    hazard = match1 | match2;

`ifdef OPERAND_FWD_EN
    fwd1        = match1;
    fwd2        = match2;
    o_dec_ready = (state == IDLE);
`else
    fwd1        = 1'b0;
    fwd2        = 1'b0;
    o_dec_ready = (state == IDLE) & ~hazard;
`endif

    need1 = ~skip1 & ~fwd1;
    need2 = ~skip2 & ~fwd2;

    // a source is finished once its address has been accepted and its data
    // captured; looking at this cycle's handshakes lets OUT follow directly
    done1_nxt = (~o_rs1_arvalid | i_rs1_arready) & (~o_rs1_rready | i_rs1_rvalid);
    done2_nxt = (~o_rs2_arvalid | i_rs2_arready) & (~o_rs2_rready | i_rs2_rvalid);

    o_wb_ready = ~o_rd_wvalid | i_rd_wready;
  end

  // Operand fetch FSM: accept decode, issue reads, capture data, present result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      o_rs1_arvalid <= 1'b0;
      o_rs2_arvalid <= 1'b0;
      o_rs1_rready  <= 1'b0;
      o_rs2_rready  <= 1'b0;
      o_rs1_araddr  <= '0;
      o_rs2_araddr  <= '0;
      o_op_valid    <= 1'b0;
      o_op_rs1_data <= '0;
      o_op_rs2_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dec_hs) begin
            o_rs1_araddr  <= i_dec_rs1;
            o_rs2_araddr  <= i_dec_rs2;
            o_rs1_arvalid <= need1;
            o_rs2_arvalid <= need2;
            o_rs1_rready  <= need1;
            o_rs2_rready  <= need2;
            o_op_rs1_data <= fwd1 ? o_rd_wdata : '0;
            o_op_rs2_data <= fwd2 ? o_rd_wdata : '0;
            if (!need1 && !need2) begin
              state      <= OUT;
              o_op_valid <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (o_rs1_arvalid && i_rs1_arready) o_rs1_arvalid <= 1'b0;
          if (o_rs2_arvalid && i_rs2_arready) o_rs2_arvalid <= 1'b0;
          if (o_rs1_rready && i_rs1_rvalid) begin
            o_rs1_rready  <= 1'b0;
            o_op_rs1_data <= i_rs1_rdata;
          end
          if (o_rs2_rready && i_rs2_rvalid) begin
            o_rs2_rready  <= 1'b0;
            o_op_rs2_data <= i_rs2_rdata;
          end
          if (done1_nxt && done2_nxt) begin
            state      <= OUT;
            o_op_valid <= 1'b1;
          end
        end
        OUT: begin
          if (op_hs) begin
            state      <= IDLE;
            o_op_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          o_op_valid <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry writeback buffer; a new entry may replace one draining this cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd_wvalid <= 1'b0;
      o_rd_waddr  <= '0;
      o_rd_wdata  <= '0;
    end else begin
      if (wb_hs && (i_wb_rd != 5'd0)) begin
        o_rd_wvalid <= 1'b1;
        o_rd_waddr  <= i_wb_rd;
        o_rd_wdata  <= i_wb_data;
      end else if (rd_hs) begin
        o_rd_wvalid <= 1'b0;
      end
    end
  end

endmodule
